// File: rtl/gon_psum_writeback.sv
// GON-to-GLB write-back stage: buffers GON words in a small FIFO and writes them to
// consecutive GLB addresses, either overwriting or accumulating into the stored psum.
`ifndef DATA_BITS
`define DATA_BITS 32
`endif

module gon_psum_writeback #(
  parameter int DATA_W     = `DATA_BITS,
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [ADDR_W-1:0] cfg_count,
  input  logic              cfg_accumulate,
  input  logic              GON_valid,
  output logic              GON_ready,
  input  logic [DATA_W-1:0] GON_data,
  output logic              glb_en,
  output logic              glb_we,
  output logic [ADDR_W-1:0] glb_addr,
  output logic [DATA_W-1:0] glb_wdata,
  input  logic [DATA_W-1:0] glb_rdata,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] ONE  = 1;
  localparam logic [PTR_W:0]    PONE = 1;

  typedef enum logic [2:0] {IDLE, OVW, RD, WR, FIN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] count_q, addr_q, acc_cnt_q, wr_cnt_q;
  logic [PTR_W:0]    wr_ptr, rd_ptr;
  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] head;
  logic              fifo_empty, fifo_full, in_xfer, push, pop, last_word;

  // Psum accumulation wraps modulo 2^DATA_W; no saturation, carry-out dropped.
  function automatic logic [DATA_W-1:0] wrap_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head       = fifo_mem[rd_ptr[PTR_W-1:0]];
  assign in_xfer    = (state_q == OVW) || (state_q == RD) || (state_q == WR);
  assign last_word  = (wr_cnt_q == count_q - ONE);

  // Ready depends on registered state only, never on GON_valid.
  assign GON_ready  = in_xfer && !fifo_full && (acc_cnt_q != count_q);
  assign push       = GON_valid && GON_ready;
  assign busy       = in_xfer;

  always_comb begin
    state_d   = state_q;
    glb_en    = 1'b0;
    glb_we    = 1'b0;
    glb_addr  = '0;
    glb_wdata = '0;
    pop       = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_count == '0)    state_d = FIN;
          else if (cfg_accumulate) state_d = RD;
          else                     state_d = OVW;
        end
      end
      OVW: begin
        if (!fifo_empty) begin
          glb_en    = 1'b1;
          glb_we    = 1'b1;
          glb_addr  = addr_q;
          glb_wdata = head;
          pop       = 1'b1;
          if (last_word) state_d = FIN;
        end
      end
      RD: begin
        if (!fifo_empty) begin
          glb_en   = 1'b1;
          glb_addr = addr_q;
          state_d  = WR;
        end
      end
      WR: begin
        // Head stays in the FIFO through RD so the sum uses this cycle's read data.
        glb_en    = 1'b1;
        glb_we    = 1'b1;
        glb_addr  = addr_q;
        glb_wdata = wrap_add(head, glb_rdata);
        pop       = 1'b1;
        state_d   = last_word ? FIN : RD;
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      addr_q    <= '0;
      acc_cnt_q <= '0;
      wr_cnt_q  <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        count_q   <= cfg_count;
        addr_q    <= cfg_base_addr;
        acc_cnt_q <= '0;
        wr_cnt_q  <= '0;
      end
      if (push) begin
        wr_ptr    <= wr_ptr + PONE;
        acc_cnt_q <= acc_cnt_q + ONE;
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + PONE;
        addr_q   <= addr_q + ONE;
        wr_cnt_q <= wr_cnt_q + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[PTR_W-1:0]] <= GON_data;
  end

endmodule

// File: tb/tb_gon_psum_writeback.sv
// Bench for gon_psum_writeback: SRAM model, per-cycle reference model check, and
// directed transfers with hand-computed memory contents.
`timescale 1ns/1ps

module tb_gon_psum_writeback;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] cfg_base_addr, cfg_count;
  logic          cfg_accumulate;
  logic          GON_valid, GON_ready;
  logic [DW-1:0] GON_data;
  logic          glb_en, glb_we;
  logic [AW-1:0] glb_addr;
  logic [DW-1:0] glb_wdata, glb_rdata;
  logic          busy, done;

  gon_psum_writeback #(.DATA_W(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_base_addr(cfg_base_addr),
    .cfg_count(cfg_count), .cfg_accumulate(cfg_accumulate),
    .GON_valid(GON_valid), .GON_ready(GON_ready), .GON_data(GON_data),
    .glb_en(glb_en), .glb_we(glb_we), .glb_addr(glb_addr),
    .glb_wdata(glb_wdata), .glb_rdata(glb_rdata), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // SRAM with one-cycle read latency
  logic [DW-1:0] sram [0:4095];
  logic          clear_mem;
  always @(posedge clk) begin
    if (clear_mem) begin
      for (int i = 0; i < 4096; i++) sram[i] <= '0;
      glb_rdata <= '0;
    end else if (glb_en) begin
      if (glb_we) sram[glb_addr] <= glb_wdata;
      else        glb_rdata <= sram[glb_addr];
    end
  end

  int n_vec = 0, n_err = 0;

  // Reference model: transfer state, queue of accepted words, expected memory
  bit            m_active, m_done_due, m_acc, m_rd_pend, saw_stall;
  int            m_count, m_accepted, m_written;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] q[$];
  logic [DW-1:0] ref_mem [0:4095];
  int            hs_total, done_cnt, wr_total;
  logic [DW-1:0] wq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    bit idle_now, next_done, exp_ready, exp_en, exp_we;
    logic [DW-1:0] w, e;
    if (!rst) begin
      chk("reset_outputs", {15'd0, GON_ready, glb_en, glb_we, busy, done, glb_addr, glb_wdata}, 64'd0);
      m_active = 0; m_done_due = 0; m_rd_pend = 0; q.delete();
      return;
    end
    idle_now = !m_active && !m_done_due;
    chk("done", done, m_done_due);
    chk("busy", busy, m_active);
    exp_ready = m_active && (m_accepted < m_count) && (q.size() < DEPTH);
    chk("gon_ready", GON_ready, exp_ready);
    if (m_active && m_accepted < m_count && !GON_ready) saw_stall = 1;
    exp_en = m_active && (q.size() > 0);
    chk("glb_en", glb_en, exp_en);
    next_done = 0;
    if (glb_en && exp_en) begin
      exp_we = !m_acc || m_rd_pend;
      chk("glb_we", glb_we, exp_we);
      chk("glb_addr", glb_addr, m_addr);
      if (exp_we) begin
        w = q.pop_front();
        e = m_acc ? ref_mem[m_addr] + w : w;
        chk("glb_wdata", glb_wdata, e);
        ref_mem[m_addr] = e;
        m_addr++; m_written++; wr_total++; m_rd_pend = 0;
      end else begin
        m_rd_pend = 1;
      end
    end
    if (m_active && m_written == m_count) begin
      m_active = 0;
      next_done = 1;
    end
    if (GON_valid && GON_ready) begin
      q.push_back(GON_data);
      m_accepted++; hs_total++;
    end
    if (start && idle_now) begin
      m_count = int'(cfg_count); m_acc = cfg_accumulate; m_addr = cfg_base_addr;
      m_accepted = 0; m_written = 0; m_rd_pend = 0;
      if (cfg_count == 0) next_done = 1;
      else m_active = 1;
    end
    if (done) done_cnt++;
    m_done_due = next_done;
  endtask

  task automatic step();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(input logic [AW-1:0] base, input logic [AW-1:0] cnt, input bit acc);
    start = 1; cfg_base_addr = base; cfg_count = cnt; cfg_accumulate = acc;
    step();
    start = 0;
  endtask

  task automatic send(input int n, input bit sparse, input bit hold_extra,
                      input int stop_after, input int mid_start_at);
    int idx, cyc, d0;
    bit hs;
    idx = 0; cyc = 0; d0 = done_cnt;
    while (done_cnt == d0 && cyc < 200 && !(stop_after >= 0 && idx >= stop_after)) begin
      start = (cyc == mid_start_at);
      if (start) begin cfg_base_addr = 12'h700; cfg_count = 12'd3; cfg_accumulate = 0; end
      if (idx < n && (!sparse || $urandom_range(0, 2) != 0)) begin
        GON_valid = 1; GON_data = wq[idx];
      end else if (hold_extra && idx >= n) begin
        GON_valid = 1; GON_data = 32'hDEAD_BEEF;
      end else begin
        GON_valid = 0; GON_data = $urandom;
      end
      @(negedge clk);
      hs = GON_valid && GON_ready;
      compare_cycle();
      @(posedge clk);
      #1;
      if (hs) idx++;
      cyc++;
    end
    GON_valid = 0; start = 0;
    if (stop_after < 0) chk("done_seen", 64'(done_cnt - d0), 64'd1);
  endtask

  int hs0, wr0;

  initial begin
    rst = 0; start = 0; cfg_base_addr = '0; cfg_count = '0; cfg_accumulate = 0;
    GON_valid = 0; GON_data = '0; clear_mem = 1;
    m_active = 0; m_done_due = 0; m_acc = 0; m_rd_pend = 0; saw_stall = 0;
    m_count = 0; m_accepted = 0; m_written = 0; m_addr = '0;
    hs_total = 0; done_cnt = 0; wr_total = 0;
    for (int i = 0; i < 4096; i++) ref_mem[i] = '0;
    step(); step();
    clear_mem = 0; rst = 1;
    step();

    // Overwrite burst
    wq = '{32'd1, 32'd2, 32'd3, 32'd4};
    hs0 = hs_total;
    start_xfer(12'h010, 12'd4, 0);
    send(4, 0, 1, -1, -1);
    chk("ovw_handshakes", 64'(hs_total - hs0), 64'd4);
    for (int i = 0; i < 4; i++) chk("ovw_mem", sram[12'h010 + i], 64'(i + 1));

    // Accumulate over preloaded 100s
    wq = '{32'd100, 32'd100, 32'd100};
    start_xfer(12'h011, 12'd3, 0);
    send(3, 0, 0, -1, -1);
    wq = '{32'd5, 32'd6, 32'd7};
    start_xfer(12'h011, 12'd3, 1);
    send(3, 0, 0, -1, -1);
    chk("acc_mem0", sram[12'h011], 64'd105);
    chk("acc_mem1", sram[12'h012], 64'd106);
    chk("acc_mem2", sram[12'h013], 64'd107);

    // Accumulate long enough for the FIFO to fill
    wq = '{32'd10, 32'd11, 32'd12, 32'd13, 32'd14, 32'd15, 32'd16, 32'd17};
    saw_stall = 0;
    start_xfer(12'h020, 12'd8, 1);
    send(8, 0, 1, -1, -1);
    chk("acc_fifo_full_stall", saw_stall, 1);
    chk("acc8_first", sram[12'h020], 64'd10);
    chk("acc8_last", sram[12'h027], 64'd17);

    // Address wrap and sum wrap
    wq = '{32'h0000_00AA, 32'h0000_00BB};
    start_xfer(12'hFFF, 12'd2, 0);
    send(2, 0, 0, -1, -1);
    chk("wrap_fff", sram[12'hFFF], 64'h0AA);
    chk("wrap_000", sram[12'h000], 64'h0BB);
    wq = '{32'hFFFF_FFFF};
    start_xfer(12'h005, 12'd1, 0);
    send(1, 0, 0, -1, -1);
    wq = '{32'd2};
    start_xfer(12'h005, 12'd1, 1);
    send(1, 0, 0, -1, -1);
    chk("sum_wrap", sram[12'h005], 64'd1);

    // Sparse valid, extra words offered, ignored mid-transfer start
    wq = '{32'h1000, 32'h1001, 32'h1002, 32'h1003, 32'h1004, 32'h1005, 32'h1006, 32'h1007};
    hs0 = hs_total;
    start_xfer(12'h080, 12'd8, 0);
    send(8, 1, 1, -1, 5);
    chk("sparse_handshakes", 64'(hs_total - hs0), 64'd8);
    for (int i = 0; i < 8; i++) chk("sparse_mem", sram[12'h080 + i], 64'(32'h1000 + i));
    chk("mid_start_ignored", sram[12'h700], 64'd0);

    // Zero count
    hs0 = hs_total; wr0 = wr_total;
    start_xfer(12'h100, 12'd0, 0);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_ready", GON_ready, 0);
    GON_valid = 1; GON_data = 32'h55;
    step(); step(); step();
    GON_valid = 0;
    chk("zero_handshakes", 64'(hs_total - hs0), 64'd0);
    chk("zero_writes", 64'(wr_total - wr0), 64'd0);

    // Reset mid-transfer, then a fresh accumulate from an empty FIFO
    wq = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6};
    start_xfer(12'h040, 12'd6, 1);
    send(6, 0, 0, 2, -1);
    rst = 0;
    #1;
    chk("async_reset_outputs",
        {15'd0, GON_ready, glb_en, glb_we, busy, done, glb_addr, glb_wdata}, 64'd0);
    step();
    rst = 1;
    step();
    wq = '{32'd9, 32'd10};
    start_xfer(12'h050, 12'd2, 1);
    send(2, 0, 0, -1, -1);
    chk("post_reset_mem0", sram[12'h050], 64'd9);
    chk("post_reset_mem1", sram[12'h051], 64'd10);
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
